// File: rtl/alu_seq_param.sv
// Handshaked WIDTH-bit ALU: 16 ops, accumulator, sticky carry and a shift-add multiplier.
// One op in flight; single-cycle ops answer next cycle, MUL after WIDTH cycles.
module alu_seq_param #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             use_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [4:0]       flags
);
    localparam int unsigned SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [3:0] OpAdd    = 4'd0;
    localparam logic [3:0] OpSub    = 4'd1;
    localparam logic [3:0] OpAnd    = 4'd2;
    localparam logic [3:0] OpOr     = 4'd3;
    localparam logic [3:0] OpXor    = 4'd4;
    localparam logic [3:0] OpNor    = 4'd5;
    localparam logic [3:0] OpNot    = 4'd6;
    localparam logic [3:0] OpPass   = 4'd7;
    localparam logic [3:0] OpAdc    = 4'd8;
    localparam logic [3:0] OpSbb    = 4'd9;
    localparam logic [3:0] OpShl    = 4'd10;
    localparam logic [3:0] OpShr    = 4'd11;
    localparam logic [3:0] OpSar    = 4'd12;
    localparam logic [3:0] OpMul    = 4'd13;
    localparam logic [3:0] OpCmp    = 4'd14;
    localparam logic [3:0] OpClrAcc = 4'd15;

    typedef enum logic [0:0] {StIdle, StMul} state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic                 cs_q, cs_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [4:0]           flags_q, flags_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [SHW-1:0]       cnt_q, cnt_d;

    logic [WIDTH-1:0]     opa;
    logic [SHW-1:0]       amt;
    logic [WIDTH:0]       add_full, sub_full, shl_full, shr_full, sar_full;
    logic                 add_v, sub_v;
    logic [WIDTH-1:0]     alu_res, flag_src;
    logic                 alu_c, alu_v;
    logic [4:0]           alu_flags;
    logic [2*WIDTH-1:0]   prod_step;
    logic [4:0]           mul_flags;
    logic                 accept;

    // Datapath: every op except MUL resolves combinationally from the presented operands.
    always_comb begin
        opa      = use_acc ? acc_q : a;
        amt      = b[SHW-1:0];
        add_full = {1'b0, opa} + {1'b0, b} + {{WIDTH{1'b0}}, (op == OpAdc) & cs_q};
        sub_full = {1'b0, opa} - {1'b0, b} - {{WIDTH{1'b0}}, (op == OpSbb) & cs_q};
        // Extra bit on the out-going side captures the last bit shifted out.
        shl_full = {1'b0, opa} << amt;
        shr_full = {opa, 1'b0} >> amt;
        sar_full = $unsigned($signed({opa, 1'b0}) >>> amt);
        add_v    = (opa[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != opa[WIDTH-1]);
        sub_v    = (opa[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != opa[WIDTH-1]);

        alu_res  = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        case (op)
            OpAdd, OpAdc: begin
                alu_res = add_full[WIDTH-1:0];
                alu_c   = add_full[WIDTH];
                alu_v   = add_v;
            end
            OpSub, OpSbb: begin
                alu_res = sub_full[WIDTH-1:0];
                alu_c   = sub_full[WIDTH];
                alu_v   = sub_v;
            end
            OpAnd:    alu_res = opa & b;
            OpOr:     alu_res = opa | b;
            OpXor:    alu_res = opa ^ b;
            OpNor:    alu_res = ~(opa | b);
            OpNot:    alu_res = ~opa;
            OpPass:   alu_res = b;
            OpShl: begin
                alu_res = shl_full[WIDTH-1:0];
                alu_c   = shl_full[WIDTH];
            end
            OpShr: begin
                alu_res = shr_full[WIDTH:1];
                alu_c   = shr_full[0];
            end
            OpSar: begin
                alu_res = sar_full[WIDTH:1];
                alu_c   = sar_full[0];
            end
            OpMul:    alu_res = '0;
            OpCmp: begin
                alu_res = opa;
                alu_c   = sub_full[WIDTH];
                alu_v   = sub_v;
            end
            OpClrAcc: alu_res = '0;
        endcase

        // CMP reports the flags of the difference while returning A unchanged.
        flag_src  = (op == OpCmp) ? sub_full[WIDTH-1:0] : alu_res;
        alu_flags = {^flag_src, alu_v, flag_src[WIDTH-1], flag_src == '0, alu_c};

        prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);
        mul_flags = {^prod_step[WIDTH-1:0], 1'b0, prod_step[WIDTH-1], prod_step == '0, 1'b0};
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cs_d        = cs_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        hi_d        = hi_q;
        flags_d     = flags_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        prod_d      = prod_q;
        cnt_d       = cnt_q;

        in_ready = (state_q == StIdle) && (!out_valid_q || out_ready);
        accept   = in_valid && in_ready;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (op == OpMul) begin
                        state_d  = StMul;
                        mcand_d  = {{WIDTH{1'b0}}, opa};
                        mplier_d = b;
                        prod_d   = '0;
                        cnt_d    = '0;
                    end else begin
                        result_d    = alu_res;
                        hi_d        = '0;
                        flags_d     = alu_flags;
                        out_valid_d = 1'b1;
                        if (op == OpClrAcc) begin
                            acc_d = '0;
                            cs_d  = 1'b0;
                        end else if (op != OpCmp) begin
                            acc_d = alu_res;
                        end
                        if (op == OpAdd || op == OpSub || op == OpAdc || op == OpSbb ||
                            op == OpCmp) begin
                            cs_d = alu_c;
                        end
                    end
                end
            end
            StMul: begin
                prod_d   = prod_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + SHW'(1);
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    state_d     = StIdle;
                    result_d    = prod_step[WIDTH-1:0];
                    hi_d        = prod_step[2*WIDTH-1:WIDTH];
                    flags_d     = mul_flags;
                    out_valid_d = 1'b1;
                    acc_d       = prod_step[WIDTH-1:0];
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            cs_q        <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            hi_q        <= '0;
            flags_q     <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            prod_q      <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cs_q        <= cs_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            hi_q        <= hi_d;
            flags_q     <= flags_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            prod_q      <= prod_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign hi        = hi_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_alu_seq_param.sv
// Scoreboard bench for alu_seq_param (WIDTH=8): directed ops with hand-computed results,
// plus latency, backpressure and mid-MUL reset checks.
module tb_alu_seq_param;
    localparam int unsigned W = 8;

    localparam logic [3:0] ADD = 4'd0,  SUB = 4'd1,  AND_ = 4'd2, OR_ = 4'd3;
    localparam logic [3:0] XOR_ = 4'd4, NOR_ = 4'd5, NOT_ = 4'd6, PASS = 4'd7;
    localparam logic [3:0] ADC = 4'd8,  SBB = 4'd9,  SHL = 4'd10, SHR = 4'd11;
    localparam logic [3:0] SAR = 4'd12, MUL = 4'd13, CMP = 4'd14, CLR = 4'd15;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         use_acc;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [W-1:0] hi;
    logic [4:0]   flags;

    alu_seq_param #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .use_acc   (use_acc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .hi        (hi),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] r;
        logic [W-1:0] h;
        logic [4:0]   f;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every output transfer pops and compares one scoreboard entry.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got result %h hi %h with empty scoreboard",
                         result, hi);
            end else begin
                mon_e = sb.pop_front();
                chk("result", {24'h0, result}, {24'h0, mon_e.r});
                chk("hi", {24'h0, hi}, {24'h0, mon_e.h});
                chk("flags", {27'h0, flags}, {27'h0, mon_e.f});
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [3:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic ua, input logic [W-1:0] er, input logic [W-1:0] eh,
                        input logic [4:0] ef);
        exp_t e;
        bit   done = 1'b0;
        in_valid = 1'b1;
        op       = o;
        a        = av;
        b        = bv;
        use_acc  = ua;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e.r = er;
                e.h = eh;
                e.f = ef;
                sb.push_back(e);
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: op %0d not accepted within 64 cycles", o);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        op        = '0;
        a         = '0;
        b         = '0;
        use_acc   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'h0, in_ready}, 32'd1);
        chk("rst_result", {24'h0, result}, 32'h0);
        chk("rst_hi", {24'h0, hi}, 32'h0);
        chk("rst_flags", {27'h0, flags}, 32'h0);
        @(posedge clk);
        #1;

        // flags = {P,V,N,Z,C}
        send(ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 5'b00011);
        @(negedge clk);
        chk("add_latency1", {31'h0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        send(ADC, 8'h00, 8'h00, 1'b0, 8'h01, 8'h00, 5'b10000);
        send(SUB, 8'h80, 8'h01, 1'b0, 8'h7F, 8'h00, 5'b11000);
        send(SBB, 8'h00, 8'h7F, 1'b1, 8'h00, 8'h00, 5'b00010);
        send(CMP, 8'h05, 8'h06, 1'b0, 8'h05, 8'h00, 5'b00101);
        send(ADD, 8'hAA, 8'h00, 1'b1, 8'h00, 8'h00, 5'b00010);  // acc still 00 after CMP
        send(CLR, 8'h12, 8'h34, 1'b0, 8'h00, 8'h00, 5'b00010);
        send(ADD, 8'h77, 8'h03, 1'b1, 8'h03, 8'h00, 5'b00000);
        send(AND_, 8'hF0, 8'h3C, 1'b0, 8'h30, 8'h00, 5'b00000);
        send(OR_, 8'hF0, 8'h0F, 1'b0, 8'hFF, 8'h00, 5'b00100);
        send(XOR_, 8'hAA, 8'hFF, 1'b0, 8'h55, 8'h00, 5'b00000);
        send(NOR_, 8'h00, 8'h00, 1'b0, 8'hFF, 8'h00, 5'b00100);
        send(NOT_, 8'h0F, 8'h00, 1'b0, 8'hF0, 8'h00, 5'b00100);
        send(PASS, 8'h00, 8'h01, 1'b0, 8'h01, 8'h00, 5'b10000);
        send(SHL, 8'h81, 8'h01, 1'b0, 8'h02, 8'h00, 5'b10001);
        send(SHR, 8'h81, 8'h01, 1'b0, 8'h40, 8'h00, 5'b10001);
        send(SAR, 8'h81, 8'h02, 1'b0, 8'hE0, 8'h00, 5'b10100);
        send(SHL, 8'h55, 8'h00, 1'b0, 8'h55, 8'h00, 5'b00000);

        // MUL: busy for 8 cycles, result on the 8th edge after accept
        send(MUL, 8'hFF, 8'hFF, 1'b0, 8'h01, 8'hFE, 5'b10000);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("mul_busy_out_valid", {31'h0, out_valid}, 32'd0);
            chk("mul_busy_in_ready", {31'h0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("mul_done_out_valid", {31'h0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        send(MUL, 8'h00, 8'h05, 1'b0, 8'h00, 8'h00, 5'b00010);
        repeat (10) @(posedge clk);
        #1;

        // Backpressure: output held three cycles, then drain and accept on the same edge
        out_ready = 1'b0;
        send(PASS, 8'h00, 8'h3C, 1'b0, 8'h3C, 8'h00, 5'b00000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_out_valid", {31'h0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'h0, in_ready}, 32'd0);
            chk("bp_result", {24'h0, result}, 32'h3C);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b1;
        op        = ADD;
        a         = 8'h01;
        b         = 8'h01;
        use_acc   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("b2b_in_ready", {31'h0, in_ready}, 32'd1);
        if (in_ready) begin
            mon_e.r = 8'h02;
            mon_e.h = 8'h00;
            mon_e.f = 5'b10000;
            sb.push_back(mon_e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_out_valid", {31'h0, out_valid}, 32'd1);
        chk("b2b_result", {24'h0, result}, 32'h02);
        @(posedge clk);
        #1;

        // Reset during MUL: aborted, no output, accumulator cleared
        send(PASS, 8'h00, 8'h09, 1'b0, 8'h09, 8'h00, 5'b00000);
        in_valid = 1'b1;
        op       = MUL;
        a        = 8'h03;
        b        = 8'h03;
        @(negedge clk);
        chk("mul2_accept", {31'h0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mul_out_valid", {31'h0, out_valid}, 32'd0);
        chk("rst_mul_in_ready", {31'h0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        send(ADD, 8'h5A, 8'h02, 1'b1, 8'h02, 8'h00, 5'b10000);

        for (int i = 0; i < 100 && sb.size() != 0; i++) begin
            @(posedge clk);
        end
        chk("scoreboard_drained", sb.size(), 32'd0);
        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
